// File: rtl/mod_amplitude_param_if.sv
// Sample/parameter bundle between the carrier source and the AM block.
// The master drives carrier and controls; the slave returns the modulated sample.
interface mod_amplitude_param_if #(
   parameter int SAMPLE_W = 8,
   parameter int PHASE_W  = 16
);
   logic                sample_en_i;
   logic [PHASE_W-1:0]  freq_i;
   logic [3:0]          mod_shift_i;
   logic [1:0]          mode_i;
   logic [SAMPLE_W-1:0] depth_i;
   logic                phase_rst_i;
   logic [SAMPLE_W-1:0] carrier_i;
   logic [SAMPLE_W-1:0] sample_data_o;
   logic                valid_o;

   modport master (
      output sample_en_i, freq_i, mod_shift_i, mode_i,
      output depth_i, phase_rst_i, carrier_i,
      input  sample_data_o, valid_o
   );

   modport slave (
      input  sample_en_i, freq_i, mod_shift_i, mode_i,
      input  depth_i, phase_rst_i, carrier_i,
      output sample_data_o, valid_o
   );
endinterface

// File: rtl/mod_amplitude_param.sv
// Amplitude modulator: internal LFO scales an external carrier by a
// depth-controlled gain through a 3-stage pipeline.
module mod_amplitude_param #(
   parameter int SAMPLE_W = 8,
   parameter int PHASE_W  = 16
) (
   input logic clk_i,
   input logic rstn_i,
   mod_amplitude_param_if.slave bus
);
   localparam logic [SAMPLE_W-1:0] MAX = '1;
   localparam logic [SAMPLE_W-1:0] ZW  = '0;

   logic [PHASE_W-1:0]    phase;
   logic [PHASE_W-1:0]    inc;
   logic [PHASE_W:0]      sum;
   logic                  carry;
   logic [1:0]            mode_q;
   logic [SAMPLE_W-1:0]   depth_q;
   logic [SAMPLE_W-1:0]   x;
   logic [SAMPLE_W-1:0]   m;

   logic [SAMPLE_W-1:0]   c1, m1, d1;
   logic                  v1;
   logic [2*SAMPLE_W-1:0] atten;
   logic [SAMPLE_W-1:0]   gain;
   logic [SAMPLE_W-1:0]   c2, g2;
   logic                  v2;
   logic [2*SAMPLE_W-1:0] prod;

   assign inc   = bus.freq_i >> bus.mod_shift_i;
   assign sum   = {1'b0, phase} + {1'b0, inc};
   assign carry = sum[PHASE_W];
   assign x     = phase[PHASE_W-2 -: SAMPLE_W];

   always_comb begin
      m = x;
      unique case (1'b1)
         (mode_q == 2'd1): m = phase[PHASE_W-1 -: SAMPLE_W];
         (mode_q == 2'd2): m = phase[PHASE_W-1] ? '0 : MAX;
         default:          m = phase[PHASE_W-1] ? ~x : x;
      endcase
   end

   // Parameters only change at an LFO wrap or restart, so the
   // modulation envelope never jumps mid-cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         phase   <= '0;
         mode_q  <= 2'd0;
         depth_q <= MAX;
      end else if (bus.phase_rst_i) begin
         phase   <= '0;
         mode_q  <= bus.mode_i;
         depth_q <= bus.depth_i;
      end else if (bus.sample_en_i) begin
         phase <= sum[PHASE_W-1:0];
         if (carry) begin
            mode_q  <= bus.mode_i;
            depth_q <= bus.depth_i;
         end
      end
   end

   assign atten = {ZW, d1} * {ZW, MAX - m1};
   assign gain  = MAX - SAMPLE_W'(atten >> SAMPLE_W);
   assign prod  = {ZW, c2} * {ZW, g2};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         c1 <= '0;
         m1 <= '0;
         d1 <= '0;
         v1 <= 1'b0;
         c2 <= '0;
         g2 <= '0;
         v2 <= 1'b0;
         bus.sample_data_o <= '0;
         bus.valid_o       <= 1'b0;
      end else begin
         v1 <= bus.sample_en_i;
         if (bus.sample_en_i) begin
            c1 <= bus.carrier_i;
            m1 <= m;
            d1 <= depth_q;
         end
         c2 <= c1;
         g2 <= gain;
         v2 <= v1;
         bus.valid_o <= v2;
         if (v2) bus.sample_data_o <= SAMPLE_W'(prod >> SAMPLE_W);
      end
   end
endmodule

// File: tb/tb_mod_amplitude_param.sv
// Directed scoreboard bench for mod_amplitude_param.
// Stimulus pushes expected samples; a negedge monitor pops and compares.
module tb_mod_amplitude_param;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   typedef struct {
      logic [7:0] data;
      int         stamp;
      string      name;
   } exp_t;

   exp_t q[$];

   mod_amplitude_param_if #(.SAMPLE_W(8), .PHASE_W(16)) bus ();

   mod_amplitude_param #(.SAMPLE_W(8), .PHASE_W(16)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Drive one cycle of stimulus; a strobe registers its expected result.
   task automatic tick(input logic en, input logic prst,
                       input logic [7:0] car, input logic [7:0] exp,
                       input string name);
      bus.sample_en_i = en;
      bus.phase_rst_i = prst;
      bus.carrier_i   = car;
      if (en) q.push_back('{data: exp, stamp: cyc, name: name});
      @(posedge clk);
      #1;
      bus.sample_en_i = 1'b0;
      bus.phase_rst_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rstn && bus.valid_o) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid: data %0d at cycle %0d",
                     bus.sample_data_o, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.name, "_data"}, int'(bus.sample_data_o), int'(e.data));
            check({e.name, "_latency"}, cyc - e.stamp, 3);
         end
      end
   end

   initial begin
      bus.sample_en_i = 1'b0;
      bus.freq_i      = 16'h0000;
      bus.mod_shift_i = 4'd0;
      bus.mode_i      = 2'd0;
      bus.depth_i     = 8'd255;
      bus.phase_rst_i = 1'b0;
      bus.carrier_i   = 8'd0;

      #2 rstn = 1'b0;
      #1;
      check("por_valid", int'(bus.valid_o), 0);
      check("por_data", int'(bus.sample_data_o), 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      tick(1, 0, 8'd200, 8'd0, "rst_tri");

      bus.depth_i = 8'd0;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd200, 8'd199, "depth0_a");
      tick(1, 0, 8'd100, 8'd99, "depth0_b");
      tick(1, 0, 8'd200, 8'd199, "depth0_c");
      tick(0, 0, 8'd0, 8'd0, "");
      check("midstream_valid", int'(bus.valid_o), 1);
      rstn = 1'b0;
      #1;
      check("rst_valid", int'(bus.valid_o), 0);
      check("rst_data", int'(bus.sample_data_o), 0);
      q.delete();
      @(posedge clk);
      #1;
      check("rst_hold_valid", int'(bus.valid_o), 0);
      rstn = 1'b1;

      tick(1, 0, 8'd200, 8'd0, "post_rst");

      bus.depth_i = 8'd255;
      bus.mode_i  = 2'd2;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd200, 8'd199, "sq_full");
      bus.mode_i = 2'd0;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd200, 8'd0, "tri_full");

      bus.freq_i = 16'h8000;
      tick(1, 0, 8'd200, 8'd0, "wrap_1");
      bus.mode_i = 2'd2;
      tick(1, 0, 8'd200, 8'd199, "wrap_2");
      tick(1, 0, 8'd200, 8'd199, "wrap_3");
      tick(1, 0, 8'd200, 8'd0, "wrap_4");

      bus.freq_i = 16'h0100;
      bus.mode_i = 2'd1;
      tick(0, 1, 8'd0, 8'd0, "");
      repeat (3) tick(0, 0, 8'd0, 8'd0, "");
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, 8'd0, 8'd0, "");
         check("gate_valid", int'(bus.valid_o), 0);
      end
      tick(1, 0, 8'd255, 8'd0, "saw_0");
      tick(1, 0, 8'd255, 8'd1, "saw_1");
      tick(1, 0, 8'd255, 8'd2, "saw_2");
      tick(1, 0, 8'd255, 8'd3, "saw_3");

      bus.freq_i      = 16'h4000;
      bus.mod_shift_i = 4'd2;
      bus.mode_i      = 2'd0;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd255, 8'd0, "ratio_0000");
      tick(1, 0, 8'd255, 8'd32, "ratio_1000");
      tick(1, 0, 8'd255, 8'd64, "ratio_2000");
      tick(1, 0, 8'd255, 8'd96, "ratio_3000");
      tick(1, 0, 8'd255, 8'd128, "ratio_4000");
      bus.mode_i = 2'd2;
      tick(1, 1, 8'd255, 8'd160, "simul_pre");
      tick(1, 0, 8'd255, 8'd254, "simul_post");

      bus.mode_i      = 2'd0;
      bus.freq_i      = 16'h7F80;
      bus.mod_shift_i = 4'd0;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd255, 8'd0, "tri_0000");
      tick(1, 0, 8'd255, 8'd254, "tri_7f80");
      tick(1, 0, 8'd255, 8'd1, "tri_ff00");

      bus.mode_i  = 2'd2;
      bus.depth_i = 8'd128;
      bus.freq_i  = 16'h8000;
      tick(0, 1, 8'd0, 8'd0, "");
      tick(1, 0, 8'd200, 8'd199, "half_hi");
      tick(1, 0, 8'd200, 8'd100, "half_lo");

      for (int i = 0; i < 20 && q.size() != 0; i++) tick(0, 0, 8'd0, 8'd0, "");
      repeat (3) tick(0, 0, 8'd0, 8'd0, "");
      check("drain_pending", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
